mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access stage directly downstream of the execute-stage ALU.
- Consumes the ALU result (effective address or pass-through value) plus control from EX, drives the data-cache request handshake, and produces registered MEM/WB writeback values.
- Supports LW/SW and LL/SC, using a link register invalidated by coherence snoops.
- Stalls upstream while a cache access is outstanding.

Parameters:
- DATA_W, 32, datapath/address width (word_t).
- RSEL_W, 5, register-select width (regbits_t).

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- ex_valid  in  1  EX presents an instruction.
- ex_ready  out  1  stage can accept (combinational: state==IDLE).
- ex_alu_out  in  DATA_W  ALU result: address for memory ops, writeback value otherwise.
- ex_store_data  in  DATA_W  rt value for SW/SC.
- ex_ren  in  1  load (LW/LL).
- ex_wen  in  1  store (SW/SC).
- ex_ll  in  1  load-linked (with ex_ren).
- ex_sc  in  1  store-conditional (with ex_wen).
- ex_regwrite  in  1  instruction writes a register.
- ex_wsel  in  RSEL_W  destination register.
- ex_halt  in  1  HALT reached EX.
- flush  in  1  squash instruction entering this cycle.
- snoop_inv  in  1  coherence invalidate.
- snoop_addr  in  DATA_W  invalidated word address.
- dmemREN  out  1  cache read request.
- dmemWEN  out  1  cache write request.
- dmemaddr  out  DATA_W  request address (registered).
- dmemstore  out  DATA_W  store data (registered).
- dhit  in  1  cache completes request this cycle.
- dmemload  in  DATA_W  read data, valid with dhit.
- wb_valid  out  1  one-cycle pulse: writeback fields valid.
- wb_regwrite  out  1  write enable to register file.
- wb_wsel  out  RSEL_W  destination register.
- wb_data  out  DATA_W  writeback value.
- misalign  out  1  pulses with wb_valid on an unaligned memory op.
- halt  out  1  sticky halt to the system.

Behaviour:
- Reset (async, RST=1):
  - state=IDLE.
  - All outputs, link_valid, link_addr and latched fields = 0.
  - Reset mid-ACCESS drops the request the same cycle.
- FSM states: IDLE, ACCESS.
- IDLE, ex_valid && !flush accepted:
  - Non-memory op (ren=wen=0): next edge wb_valid=1, wb_data=ex_alu_out, wb_regwrite/wb_wsel copied. Latency 1; stay IDLE.
  - Memory op with ex_alu_out[1:0]!=0: no request issued. Next edge wb_valid=1, misalign=1, wb_regwrite=0.
  - SC fails if !link_valid, or link_addr!=addr, or (snoop_inv && snoop_addr==addr) in the same cycle (invalidate wins). On failure: no request; next edge wb_valid=1, wb_data=0, wb_regwrite=ex_regwrite; link_valid<=0.
  - Otherwise: latch address, store data and control; go ACCESS.
- IDLE, ex_valid && flush: instruction dropped, no state change.
- ACCESS:
  - dmemREN/dmemWEN held from registers; addr and store stable until dhit.
  - ex_ready=0.
  - On dhit: dmem requests deassert next edge, state=IDLE, wb_valid=1.
  - wb_data on dhit: dmemload for loads, 1 for a successful SC.
  - flush during ACCESS does not abort the access.
- LL completion (dhit): link_valid<=1, link_addr<=address.
- Link clears on any of:
  - own SW/SC completing to link_addr;
  - snoop_inv with snoop_addr==link_addr, in any state.
  - If a snoop-clear and LL completion coincide, the LL set wins (newer).
- Halt: ex_valid && ex_halt && !flush sets halt next edge. halt stays set until reset; no further instructions accepted.
- Addresses compared at full DATA_W, with bits [1:0] zero.

Decomposition:
- cpu_types_pkg: word_t, regbits_t, mem_state_t {IDLE, ACCESS}, WORD_ALIGN_MASK constant.
- Sub-module link_reg: link_valid/link_addr, set/clear/snoop compare, sc_ok output.

Test Plan:
- Non-memory pass-through:
  - Stimulus: ADD result 0x0000_0042, wsel=5.
  - Response: next cycle wb_valid=1, wb_data=0x42, wb_wsel=5; dmemREN never asserted.
- Load with wait states:
  - Stimulus: LW addr 0x100; dhit after 3 cycles with dmemload=0xDEADBEEF.
  - Response: dmemREN=1 for exactly 3 cycles, ex_ready=0 throughout; wb_data=0xDEADBEEF one cycle after dhit.
- Store misaligned:
  - Stimulus: SW addr 0x102.
  - Response: no dmemWEN; misalign=1, wb_valid=1, wb_regwrite=0 next cycle.
- LL/SC success:
  - Stimulus: LL 0x200, then SC 0x200 data 0x7.
  - Response: dmemWEN with dmemstore=0x7; wb_data=1; link_valid=0 afterwards.
- LL/SC with snoop:
  - Stimulus: LL 0x200; snoop_inv addr 0x200 in the same cycle SC 0x200 is presented.
  - Response: no write; wb_data=0.
- Reset mid-access:
  - Stimulus: assert RST while in ACCESS.
  - Response: dmemREN/WEN=0 immediately, state IDLE, halt=0, wb_valid=0.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types for the memory-access stage.
// Word and register-select widths, MEM FSM states, word alignment mask.
package cpu_types_pkg;
    localparam int WORD_W    = 32;
    localparam int RSEL_BITS = 5;

    typedef logic [WORD_W-1:0]    word_t;
    typedef logic [RSEL_BITS-1:0] regbits_t;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } mem_state_t;

    localparam word_t WORD_ALIGN_MASK = 32'hFFFF_FFFC;
endpackage

// File: rtl/mem_stage_if.sv
// Data-cache request/response handshake between MEM stage and dcache.
// The stage is master: it issues requests and waits for dhit.
interface mem_stage_if #(
    parameter int DATA_W = 32
);
    logic              dmemREN;
    logic              dmemWEN;
    logic [DATA_W-1:0] dmemaddr;
    logic [DATA_W-1:0] dmemstore;
    logic              dhit;
    logic [DATA_W-1:0] dmemload;

    modport master (
        output dmemREN, dmemWEN, dmemaddr, dmemstore,
        input  dhit, dmemload
    );

    modport slave (
        input  dmemREN, dmemWEN, dmemaddr, dmemstore,
        output dhit, dmemload
    );
endinterface

// File: rtl/mem_stage_link_reg.sv
// LL/SC link register: set by LL, cleared by own stores, SC failure
// and coherence snoops. Addresses arrive already word-aligned.
module link_reg #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              set,
    input  logic [DATA_W-1:0] set_addr,
    input  logic              clr,
    input  logic [DATA_W-1:0] clr_addr,
    input  logic              kill,
    input  logic              snoop_inv,
    input  logic [DATA_W-1:0] snoop_addr,
    input  logic [DATA_W-1:0] chk_addr,
    output logic              sc_ok,
    output logic              link_valid,
    output logic [DATA_W-1:0] link_addr
);
    logic hit_clr;
    logic hit_snoop;

    assign hit_clr   = clr && (clr_addr == link_addr);
    assign hit_snoop = snoop_inv && (snoop_addr == link_addr);

    // A snoop to the checked address in the same cycle beats the link
    assign sc_ok = link_valid && (link_addr == chk_addr) &&
                   !(snoop_inv && (snoop_addr == chk_addr));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            link_valid <= 1'b0;
            link_addr  <= '0;
        end else if (set) begin
            link_valid <= 1'b1;
            link_addr  <= set_addr;
        end else if (kill || hit_clr || hit_snoop) begin
            link_valid <= 1'b0;
        end
    end
endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: dcache handshake, LW/SW/LL/SC, registered writeback.
// Holds EX (ex_ready=0) while a cache access is outstanding.
module mem_stage
    import cpu_types_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int RSEL_W = 5
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [DATA_W-1:0] ex_alu_out,
    input  logic [DATA_W-1:0] ex_store_data,
    input  logic              ex_ren,
    input  logic              ex_wen,
    input  logic              ex_ll,
    input  logic              ex_sc,
    input  logic              ex_regwrite,
    input  logic [RSEL_W-1:0] ex_wsel,
    input  logic              ex_halt,
    input  logic              flush,
    input  logic              snoop_inv,
    input  logic [DATA_W-1:0] snoop_addr,
    mem_stage_if.master       dc,
    output logic              wb_valid,
    output logic              wb_regwrite,
    output logic [RSEL_W-1:0] wb_wsel,
    output logic [DATA_W-1:0] wb_data,
    output logic              misalign,
    output logic              halt
);
    localparam logic [0:0] ST_IDLE   = IDLE;
    localparam logic [0:0] ST_ACCESS = ACCESS;
    localparam logic [DATA_W-1:0] AMASK = ~DATA_W'(~WORD_ALIGN_MASK);

    logic [0:0]        state;
    logic              req_ren, req_wen, req_ll, req_sc;
    logic [DATA_W-1:0] addr_q, store_q;
    logic              rw_q;
    logic [RSEL_W-1:0] wsel_q;

    logic              idle, accept, is_mem, unaligned;
    logic              sc_ok, sc_bad, go, done;
    logic              op_alu, op_mis, op_scf;
    logic [DATA_W-1:0] word_addr;
    logic              link_valid;
    logic [DATA_W-1:0] link_addr;

    assign idle      = (state == ST_IDLE);
    assign ex_ready  = idle;
    assign accept    = ex_valid && idle && !flush && !halt;
    assign is_mem    = ex_ren || ex_wen;
    assign unaligned = |ex_alu_out[1:0];
    assign word_addr = ex_alu_out & AMASK;
    assign sc_bad    = ex_sc && ex_wen && !sc_ok;
    assign done      = !idle && dc.dhit;

    // Mutually exclusive decode of an accepted instruction
    assign op_alu = !is_mem;
    assign op_mis = is_mem && unaligned;
    assign op_scf = is_mem && !unaligned && sc_bad;
    assign go     = accept && is_mem && !unaligned && !sc_bad;

    assign dc.dmemREN   = req_ren;
    assign dc.dmemWEN   = req_wen;
    assign dc.dmemaddr  = addr_q;
    assign dc.dmemstore = store_q;

    link_reg #(.DATA_W(DATA_W)) u_link (
        .clk        (CLK),
        .rst        (RST),
        .set        (done && req_ll),
        .set_addr   (addr_q),
        .clr        (done && req_wen),
        .clr_addr   (addr_q),
        .kill       (accept && op_scf),
        .snoop_inv  (snoop_inv),
        .snoop_addr (snoop_addr & AMASK),
        .chk_addr   (word_addr),
        .sc_ok      (sc_ok),
        .link_valid (link_valid),
        .link_addr  (link_addr)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= ST_IDLE;
            req_ren     <= 1'b0;
            req_wen     <= 1'b0;
            req_ll      <= 1'b0;
            req_sc      <= 1'b0;
            addr_q      <= '0;
            store_q     <= '0;
            rw_q        <= 1'b0;
            wsel_q      <= '0;
            wb_valid    <= 1'b0;
            wb_regwrite <= 1'b0;
            wb_wsel     <= '0;
            wb_data     <= '0;
            misalign    <= 1'b0;
            halt        <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            misalign <= 1'b0;
            if (accept && ex_halt)
                halt <= 1'b1;
            if (accept) begin
                unique case (1'b1)
                    op_alu: begin
                        wb_valid    <= 1'b1;
                        wb_regwrite <= ex_regwrite;
                        wb_wsel     <= ex_wsel;
                        wb_data     <= ex_alu_out;
                    end
                    op_mis: begin
                        wb_valid    <= 1'b1;
                        misalign    <= 1'b1;
                        wb_regwrite <= 1'b0;
                        wb_wsel     <= ex_wsel;
                        wb_data     <= '0;
                    end
                    op_scf: begin
                        wb_valid    <= 1'b1;
                        wb_regwrite <= ex_regwrite;
                        wb_wsel     <= ex_wsel;
                        wb_data     <= '0;
                    end
                    default: begin
                        state   <= ST_ACCESS;
                        req_ren <= ex_ren;
                        req_wen <= ex_wen;
                        req_ll  <= ex_ll && ex_ren;
                        req_sc  <= ex_sc && ex_wen;
                        addr_q  <= word_addr;
                        store_q <= ex_store_data;
                        rw_q    <= ex_regwrite;
                        wsel_q  <= ex_wsel;
                    end
                endcase
            end else if (done) begin
                state       <= ST_IDLE;
                req_ren     <= 1'b0;
                req_wen     <= 1'b0;
                wb_valid    <= 1'b1;
                wb_regwrite <= rw_q;
                wb_wsel     <= wsel_q;
                wb_data     <= req_ren ? dc.dmemload : DATA_W'(req_sc);
            end
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus random
// op streams checked against a behavioural LL/SC memory-stage model.
module tb_mem_stage;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        ex_valid = 0, ex_ready;
    logic [31:0] ex_alu_out = 0, ex_store_data = 0;
    logic        ex_ren = 0, ex_wen = 0, ex_ll = 0, ex_sc = 0;
    logic        ex_regwrite = 0, ex_halt = 0, flush = 0;
    logic [4:0]  ex_wsel = 0;
    logic        snoop_inv = 0;
    logic [31:0] snoop_addr = 0;
    logic        wb_valid, wb_regwrite, misalign, halt;
    logic [4:0]  wb_wsel;
    logic [31:0] wb_data;

    mem_stage_if dc();

    mem_stage dut (
        .CLK(CLK), .RST(RST), .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_alu_out(ex_alu_out), .ex_store_data(ex_store_data),
        .ex_ren(ex_ren), .ex_wen(ex_wen), .ex_ll(ex_ll), .ex_sc(ex_sc),
        .ex_regwrite(ex_regwrite), .ex_wsel(ex_wsel), .ex_halt(ex_halt),
        .flush(flush), .snoop_inv(snoop_inv), .snoop_addr(snoop_addr),
        .dc(dc), .wb_valid(wb_valid), .wb_regwrite(wb_regwrite),
        .wb_wsel(wb_wsel), .wb_data(wb_data), .misalign(misalign),
        .halt(halt)
    );

    always #5 CLK = ~CLK;

    int total = 0, bad = 0;

    // Reference model state: the architectural link
    bit          lv = 0;
    logic [31:0] la = 0;
    bit          e_issue, e_mis, e_rw, e_chk;
    logic [31:0] e_data;

    // Observations from the last run_op
    bit          o_issued, o_ready_low, o_wbv, o_mis, o_rw, o_ren_now, o_wen_now;
    int          o_rreq, o_wreq;
    logic [31:0] o_addr, o_store, o_data;
    logic [4:0]  o_wsel;

    task automatic model_op(input bit ren, wen, ll, sc, rw,
                            input logic [31:0] alu, ld,
                            input bit snp, input logic [31:0] sa);
        logic [31:0] a, s;
        a = {alu[31:2], 2'b00};
        s = {sa[31:2], 2'b00};
        e_issue = 0; e_mis = 0; e_rw = rw; e_chk = 1; e_data = 0;
        if (!ren && !wen) begin
            e_data = alu;
        end else if (alu % 4 != 0) begin
            e_mis = 1; e_rw = 0; e_chk = 0;
        end else if (sc && (!lv || la != a || (snp && s == a))) begin
            lv = 0;
        end else begin
            e_issue = 1;
            e_data = ren ? ld : (sc ? 32'd1 : 32'd0);
            e_chk = ren || sc;
        end
        if (snp && s == la) lv = 0;
        if (e_issue && wen && a == la) lv = 0;
        if (e_issue && ren && ll) begin lv = 1; la = a; end
    endtask

    // Presents one instruction, services the cache after waitc cycles
    task automatic run_op(input bit ren, wen, ll, sc, rw,
                          input logic [31:0] alu, sd, input logic [4:0] ws,
                          input int waitc, input logic [31:0] ld,
                          input bit snp, input logic [31:0] sa, input bit fl);
        model_op(ren, wen, ll, sc, rw, alu, ld, snp, sa);
        ex_valid = 1; ex_ren = ren; ex_wen = wen; ex_ll = ll; ex_sc = sc;
        ex_regwrite = rw; ex_alu_out = alu; ex_store_data = sd; ex_wsel = ws;
        snoop_inv = snp; snoop_addr = sa;
        @(posedge CLK); #1;
        ex_valid = 0; ex_ren = 0; ex_wen = 0; ex_ll = 0; ex_sc = 0;
        snoop_inv = 0; flush = fl;
        o_issued = !wb_valid; o_rreq = 0; o_wreq = 0; o_ready_low = 1;
        o_addr = 0; o_store = 0;
        if (!wb_valid) begin
            for (int k = 1; k <= waitc; k++) begin
                if (dc.dmemREN) o_rreq++;
                if (dc.dmemWEN) o_wreq++;
                if (ex_ready) o_ready_low = 0;
                o_addr = dc.dmemaddr; o_store = dc.dmemstore;
                if (k == waitc) begin dc.dhit = 1; dc.dmemload = ld; end
                @(posedge CLK); #1;
                dc.dhit = 0;
            end
        end
        flush = 0;
        o_wbv = wb_valid; o_mis = misalign; o_rw = wb_regwrite;
        o_wsel = wb_wsel; o_data = wb_data;
        o_ren_now = dc.dmemREN; o_wen_now = dc.dmemWEN;
    endtask

    task automatic test_reset;
        @(posedge CLK); @(posedge CLK); #1;
        total++; if (ex_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b want=1", ex_ready); end
        total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL rst_wbv got=%b want=0", wb_valid); end
        total++; if (halt !== 1'b0) begin bad++; $display("FAIL rst_halt got=%b want=0", halt); end
        total++; if ({dc.dmemREN, dc.dmemWEN} !== 2'b00) begin bad++; $display("FAIL rst_req got=%b want=00", {dc.dmemREN, dc.dmemWEN}); end
        total++; if (wb_data !== 32'h0) begin bad++; $display("FAIL rst_data got=%h want=0", wb_data); end
        RST = 0;
    endtask

    task automatic test_passthru;
        run_op(0, 0, 0, 0, 1, 32'h42, 0, 5'd5, 1, 0, 0, 0, 0);
        total++; if (o_wbv !== 1'b1) begin bad++; $display("FAIL pass_wbv got=%b want=1", o_wbv); end
        total++; if (o_data !== 32'h42) begin bad++; $display("FAIL pass_data got=%h want=42", o_data); end
        total++; if (o_wsel !== 5'd5) begin bad++; $display("FAIL pass_wsel got=%0d want=5", o_wsel); end
        total++; if (o_ren_now !== 1'b0) begin bad++; $display("FAIL pass_ren got=%b want=0", o_ren_now); end
        @(posedge CLK); #1;
        total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL pass_pulse got=%b want=0", wb_valid); end
    endtask

    task automatic test_load_wait;
        run_op(1, 0, 0, 0, 1, 32'h100, 0, 5'd9, 3, 32'hDEADBEEF, 0, 0, 1);
        total++; if (o_rreq != 3) begin bad++; $display("FAIL lw_ren_cycles got=%0d want=3", o_rreq); end
        total++; if (o_ready_low !== 1'b1) begin bad++; $display("FAIL lw_ready got=%b want=1", o_ready_low); end
        total++; if (o_addr !== 32'h100) begin bad++; $display("FAIL lw_addr got=%h want=100", o_addr); end
        total++; if (o_data !== 32'hDEADBEEF) begin bad++; $display("FAIL lw_data got=%h want=deadbeef", o_data); end
        total++; if (o_ren_now !== 1'b0) begin bad++; $display("FAIL lw_ren_drop got=%b want=0", o_ren_now); end
        total++; if (o_wbv !== 1'b1) begin bad++; $display("FAIL lw_wbv got=%b want=1", o_wbv); end
    endtask

    task automatic test_misalign;
        run_op(0, 1, 0, 0, 0, 32'h102, 32'h99, 5'd0, 2, 0, 0, 0, 0);
        total++; if (o_issued !== 1'b0 || o_wen_now !== 1'b0) begin bad++; $display("FAIL mis_wen got=%b want=0", o_wen_now); end
        total++; if (o_mis !== 1'b1) begin bad++; $display("FAIL mis_flag got=%b want=1", o_mis); end
        total++; if (o_wbv !== 1'b1) begin bad++; $display("FAIL mis_wbv got=%b want=1", o_wbv); end
        total++; if (o_rw !== 1'b0) begin bad++; $display("FAIL mis_rw got=%b want=0", o_rw); end
    endtask

    task automatic test_llsc;
        run_op(1, 0, 1, 0, 1, 32'h200, 0, 5'd3, 2, 32'h55, 0, 0, 0);
        total++; if (o_data !== 32'h55) begin bad++; $display("FAIL ll_data got=%h want=55", o_data); end
        run_op(0, 1, 0, 1, 1, 32'h200, 32'h7, 5'd4, 2, 0, 0, 0, 0);
        total++; if (o_wreq != 2) begin bad++; $display("FAIL sc_wen_cycles got=%0d want=2", o_wreq); end
        total++; if (o_store !== 32'h7) begin bad++; $display("FAIL sc_store got=%h want=7", o_store); end
        total++; if (o_data !== 32'h1) begin bad++; $display("FAIL sc_ok_data got=%h want=1", o_data); end
        run_op(0, 1, 0, 1, 1, 32'h200, 32'h8, 5'd4, 2, 0, 0, 0, 0);
        total++; if (o_issued !== 1'b0) begin bad++; $display("FAIL sc_link_cleared got=%b want=0", o_issued); end
        total++; if (o_data !== 32'h0) begin bad++; $display("FAIL sc_fail_data got=%h want=0", o_data); end
    endtask

    task automatic test_llsc_snoop;
        run_op(1, 0, 1, 0, 1, 32'h200, 0, 5'd3, 1, 32'h1, 0, 0, 0);
        run_op(0, 1, 0, 1, 1, 32'h200, 32'h7, 5'd4, 2, 0, 1, 32'h200, 0);
        total++; if (o_issued !== 1'b0) begin bad++; $display("FAIL snp_write got=%b want=0", o_issued); end
        total++; if (o_data !== 32'h0 || o_wbv !== 1'b1) begin bad++; $display("FAIL snp_data got=%h want=0", o_data); end
    endtask

    task automatic test_flush;
        ex_valid = 1; flush = 1; ex_ren = 1; ex_alu_out = 32'h300;
        @(posedge CLK); #1;
        ex_valid = 0; flush = 0; ex_ren = 0;
        total++; if (wb_valid !== 1'b0 || dc.dmemREN !== 1'b0) begin bad++; $display("FAIL flush_drop got=%b%b want=00", wb_valid, dc.dmemREN); end
        total++; if (ex_ready !== 1'b1) begin bad++; $display("FAIL flush_ready got=%b want=1", ex_ready); end
    endtask

    task automatic test_random;
        logic [31:0] bases [4];
        logic [31:0] alu, sa;
        int kind, w;
        bit snp;
        bases[0] = 32'h200; bases[1] = 32'h204; bases[2] = 32'h300; bases[3] = 32'h200;
        for (int i = 0; i < 60; i++) begin
            kind = $urandom_range(0, 4);
            alu = bases[$urandom_range(0, 3)];
            if ($urandom_range(0, 7) == 0) alu = alu + $urandom_range(1, 3);
            if (kind == 0) alu = $urandom;
            snp = ($urandom_range(0, 3) == 0);
            sa = bases[$urandom_range(0, 3)];
            w = $urandom_range(1, 4);
            run_op(kind == 1 || kind == 3, kind == 2 || kind == 4, kind == 3,
                   kind == 4, 1'($urandom), alu, $urandom, 5'($urandom), w,
                   $urandom, snp, sa, 1'($urandom));
            total++; if (o_wbv !== 1'b1) begin bad++; $display("FAIL rnd_wbv i=%0d got=%b want=1", i, o_wbv); end
            total++; if (o_issued !== e_issue) begin bad++; $display("FAIL rnd_issue i=%0d got=%b want=%b", i, o_issued, e_issue); end
            total++; if (o_mis !== e_mis) begin bad++; $display("FAIL rnd_mis i=%0d got=%b want=%b", i, o_mis, e_mis); end
            total++; if (o_rw !== e_rw) begin bad++; $display("FAIL rnd_rw i=%0d got=%b want=%b", i, o_rw, e_rw); end
            total++; if (o_wsel !== ex_wsel) begin bad++; $display("FAIL rnd_wsel i=%0d got=%0d want=%0d", i, o_wsel, ex_wsel); end
            total++; if ({o_ren_now, o_wen_now} !== 2'b00) begin bad++; $display("FAIL rnd_req_drop i=%0d got=%b%b want=00", i, o_ren_now, o_wen_now); end
            if (e_chk) begin
                total++; if (o_data !== e_data) begin bad++; $display("FAIL rnd_data i=%0d got=%h want=%h", i, o_data, e_data); end
            end
            if (e_issue) begin
                total++; if (o_rreq + o_wreq != w) begin bad++; $display("FAIL rnd_req_cycles i=%0d got=%0d want=%0d", i, o_rreq + o_wreq, w); end
                total++; if (o_addr !== alu) begin bad++; $display("FAIL rnd_addr i=%0d got=%h want=%h", i, o_addr, alu); end
            end
        end
    endtask

    task automatic test_reset_mid;
        ex_valid = 1; ex_ren = 1; ex_alu_out = 32'h100;
        @(posedge CLK); #1;
        ex_valid = 0; ex_ren = 0;
        total++; if (dc.dmemREN !== 1'b1) begin bad++; $display("FAIL rmid_pre got=%b want=1", dc.dmemREN); end
        #2 RST = 1; #1;
        total++; if ({dc.dmemREN, dc.dmemWEN} !== 2'b00) begin bad++; $display("FAIL rmid_req got=%b want=00", {dc.dmemREN, dc.dmemWEN}); end
        total++; if (ex_ready !== 1'b1 || wb_valid !== 1'b0 || halt !== 1'b0) begin bad++; $display("FAIL rmid_state got=%b%b%b want=100", ex_ready, wb_valid, halt); end
        lv = 0;
        @(posedge CLK); #1;
        RST = 0;
    endtask

    task automatic test_halt;
        ex_valid = 1; ex_halt = 1;
        @(posedge CLK); #1;
        ex_valid = 0; ex_halt = 0;
        total++; if (halt !== 1'b1) begin bad++; $display("FAIL halt_set got=%b want=1", halt); end
        ex_valid = 1; ex_ren = 1; ex_alu_out = 32'h100;
        for (int k = 0; k < 3; k++) begin
            @(posedge CLK); #1;
            total++; if (wb_valid !== 1'b0 || dc.dmemREN !== 1'b0 || halt !== 1'b1) begin bad++; $display("FAIL halt_block k=%0d got=%b%b%b want=001", k, wb_valid, dc.dmemREN, halt); end
        end
        ex_valid = 0; ex_ren = 0;
    endtask

    initial begin
        dc.dhit = 0;
        dc.dmemload = 0;
        test_reset;
        test_passthru;
        test_load_wait;
        test_misalign;
        test_llsc;
        test_llsc_snoop;
        test_flush;
        test_random;
        test_reset_mid;
        test_halt;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
